// File: rtl/display_pkg.sv
// Shared 480p timing constants and helpers for the display pipeline
// (timing generator, sprite and paint stages).
package display_pkg;

    localparam int H_RES_480   = 640;
    localparam int H_FP_480    = 16;
    localparam int H_SYNC_480  = 96;
    localparam int H_BP_480    = 48;
    localparam int V_RES_480   = 480;
    localparam int V_FP_480    = 10;
    localparam int V_SYNC_480  = 2;
    localparam int V_BP_480    = 33;
    localparam int H_TOTAL_480 = H_RES_480 + H_FP_480 + H_SYNC_480 + H_BP_480;
    localparam int V_TOTAL_480 = V_RES_480 + V_FP_480 + V_SYNC_480 + V_BP_480;

    // Registered timing flags that accompany each sx,sy pair.
    typedef struct packed {
        logic hsync;
        logic vsync;
        logic de;
        logic frame;
        logic line;
    } timing_flags_t;

    // True when lo..hi is representable as a signed value of the given width.
    function automatic bit coord_fits(int lo, int hi, int width);
        return (lo >= -(2 ** (width - 1))) && (hi <= (2 ** (width - 1)) - 1);
    endfunction

endpackage

// File: rtl/display_axis_counter.sv
// One screen axis: counts POS_STA..POS_END when enabled, wrapping back to POS_STA.
// pos_next is exposed so the parent can register flags coherent with pos.
module display_axis_counter #(
    parameter int CORDW = 16,
    parameter logic signed [CORDW-1:0] POS_STA = '0,
    parameter logic signed [CORDW-1:0] POS_END = '0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    output logic signed [CORDW-1:0] pos,
    output logic signed [CORDW-1:0] pos_next,
    output logic                    wrap
);

    always_comb begin
        wrap     = en && (pos == POS_END);
        pos_next = pos;
        if (wrap) begin
            pos_next = POS_STA;
        end else if (en) begin
            pos_next = pos + CORDW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos <= POS_STA;
        end else begin
            pos <= pos_next;
        end
    end

endmodule

// File: rtl/display_timing_gen.sv
// Pixel-clock display timing: signed coordinates with blanking below zero,
// plus sync, data enable and frame/line strobes registered alongside them.
module display_timing_gen
    import display_pkg::*;
#(
    parameter int CORDW  = 16,
    parameter int H_RES  = H_RES_480,
    parameter int H_FP   = H_FP_480,
    parameter int H_SYNC = H_SYNC_480,
    parameter int H_BP   = H_BP_480,
    parameter int V_RES  = V_RES_480,
    parameter int V_FP   = V_FP_480,
    parameter int V_SYNC = V_SYNC_480,
    parameter int V_BP   = V_BP_480,
    parameter bit H_POL  = 1'b0,
    parameter bit V_POL  = 1'b0
) (
    input  logic                    clk_pix,
    input  logic                    rst_pix_n,
    output logic signed [CORDW-1:0] sx,
    output logic signed [CORDW-1:0] sy,
    output logic                    hsync,
    output logic                    vsync,
    output logic                    de,
    output logic                    frame,
    output logic                    line
);

    localparam int H_STA_I = -(H_FP + H_SYNC + H_BP);
    localparam int V_STA_I = -(V_FP + V_SYNC + V_BP);

    localparam logic signed [CORDW-1:0] H_STA  = CORDW'(H_STA_I);
    localparam logic signed [CORDW-1:0] H_END  = CORDW'(H_RES - 1);
    localparam logic signed [CORDW-1:0] HS_STA = CORDW'(H_STA_I + H_FP);
    localparam logic signed [CORDW-1:0] HS_END = CORDW'(H_STA_I + H_FP + H_SYNC);
    localparam logic signed [CORDW-1:0] V_STA  = CORDW'(V_STA_I);
    localparam logic signed [CORDW-1:0] V_END  = CORDW'(V_RES - 1);
    localparam logic signed [CORDW-1:0] VS_STA = CORDW'(V_STA_I + V_FP);
    localparam logic signed [CORDW-1:0] VS_END = CORDW'(V_STA_I + V_FP + V_SYNC);

    if (!coord_fits(H_STA_I, H_RES - 1, CORDW) || !coord_fits(V_STA_I, V_RES - 1, CORDW)) begin : g_cordw_check
        $error("display_timing_gen: CORDW=%0d cannot hold the coordinate range", CORDW);
    end

    logic signed [CORDW-1:0] sx_next;
    logic signed [CORDW-1:0] sy_next;
    logic                    h_wrap;
    logic                    v_wrap;

    display_axis_counter #(
        .CORDW   (CORDW),
        .POS_STA (H_STA),
        .POS_END (H_END)
    ) u_h_counter (
        .clk      (clk_pix),
        .rst_n    (rst_pix_n),
        .en       (1'b1),
        .pos      (sx),
        .pos_next (sx_next),
        .wrap     (h_wrap)
    );

    display_axis_counter #(
        .CORDW   (CORDW),
        .POS_STA (V_STA),
        .POS_END (V_END)
    ) u_v_counter (
        .clk      (clk_pix),
        .rst_n    (rst_pix_n),
        .en       (h_wrap),
        .pos      (sy),
        .pos_next (sy_next),
        .wrap     (v_wrap)
    );

    timing_flags_t flags_next;
    timing_flags_t flags;

    // Flags are derived from the next coordinates so they land in the same cycle as sx,sy.
    // A horizontal wrap is exactly the step onto sx == H_STA; both wraps together land on the frame start.
    always_comb begin
        flags_next       = '0;
        flags_next.hsync = ((sx_next >= HS_STA) && (sx_next < HS_END)) ? H_POL : !H_POL;
        flags_next.vsync = ((sy_next >= VS_STA) && (sy_next < VS_END)) ? V_POL : !V_POL;
        flags_next.de    = !sx_next[CORDW-1] && !sy_next[CORDW-1];
        flags_next.line  = h_wrap;
        flags_next.frame = h_wrap && v_wrap;
    end

    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            flags.hsync <= !H_POL;
            flags.vsync <= !V_POL;
            flags.de    <= 1'b0;
            flags.frame <= 1'b0;
            flags.line  <= 1'b0;
        end else begin
            flags <= flags_next;
        end
    end

    assign hsync = flags.hsync;
    assign vsync = flags.vsync;
    assign de    = flags.de;
    assign frame = flags.frame;
    assign line  = flags.line;

endmodule

// File: tb/tb_display_timing_gen.sv
// Bench for display_timing_gen: 480p reference-model scoreboard plus a tiny-timing
// instance for whole-frame counts and an SVGA instance for active-high sync.
module tb_display_timing_gen;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // 480p default instance
    logic signed [15:0] a_sx, a_sy;
    logic a_hsync, a_vsync, a_de, a_frame, a_line;
    logic [36:0] a_vec;
    assign a_vec = {a_sx, a_sy, a_hsync, a_vsync, a_de, a_frame, a_line};

    display_timing_gen u_dut_480 (
        .clk_pix (clk), .rst_pix_n (rst_n),
        .sx (a_sx), .sy (a_sy), .hsync (a_hsync), .vsync (a_vsync),
        .de (a_de), .frame (a_frame), .line (a_line)
    );

    // SVGA 800x600 instance, active-high sync
    logic signed [15:0] v_sx, v_sy;
    logic v_hsync, v_vsync, v_de, v_frame, v_line;
    logic [36:0] v_vec;
    assign v_vec = {v_sx, v_sy, v_hsync, v_vsync, v_de, v_frame, v_line};

    display_timing_gen #(
        .H_RES (800), .H_FP (40), .H_SYNC (128), .H_BP (88),
        .V_RES (600), .V_FP (1), .V_SYNC (4), .V_BP (23),
        .H_POL (1'b1), .V_POL (1'b1)
    ) u_dut_svga (
        .clk_pix (clk), .rst_pix_n (rst_n),
        .sx (v_sx), .sy (v_sy), .hsync (v_hsync), .vsync (v_vsync),
        .de (v_de), .frame (v_frame), .line (v_line)
    );

    // Tiny 32x24 instance: line 40 cycles, frame 30 lines = 1200 cycles
    logic signed [7:0] t_sx, t_sy;
    logic t_hsync, t_vsync, t_de, t_frame, t_line;
    logic [20:0] t_vec;
    assign t_vec = {t_sx, t_sy, t_hsync, t_vsync, t_de, t_frame, t_line};

    display_timing_gen #(
        .CORDW (8),
        .H_RES (32), .H_FP (2), .H_SYNC (4), .H_BP (2),
        .V_RES (24), .V_FP (1), .V_SYNC (2), .V_BP (3)
    ) u_dut_tiny (
        .clk_pix (clk), .rst_pix_n (rst_n),
        .sx (t_sx), .sy (t_sy), .hsync (t_hsync), .vsync (t_vsync),
        .de (t_de), .frame (t_frame), .line (t_line)
    );

    // Scoreboards: per-cycle 480p vectors, and event cycle stamps for the other instances
    logic [36:0] exp_q[$];
    logic [31:0] t_exp_q[$];
    logic [31:0] t_obs_q[$];
    logic [31:0] v_exp_q[$];
    logic [31:0] v_obs_q[$];
    int t_vs_cnt = 0;
    int t_de_cnt = 0;
    int v_hs_cnt = 0;
    int v_vs_rise = -1;

    always @(negedge clk) begin
        if (rst_n) begin
            if (t_frame === 1'b1 && t_obs_q.size() < 8) t_obs_q.push_back(32'(cyc));
            if (t_obs_q.size() == 1) begin
                if (t_vsync === 1'b0) t_vs_cnt++;
                if (t_de === 1'b1)    t_de_cnt++;
            end
            if (v_line === 1'b1 && v_obs_q.size() < 8) v_obs_q.push_back(32'(cyc));
            if (cyc < 1056 && v_hsync === 1'b1) v_hs_cnt++;
            if (v_vs_rise < 0 && v_vsync === 1'b1) v_vs_rise = cyc;
        end
    end

    // 480p reference model
    int m_sx, m_sy;

    function automatic logic [36:0] model_vec(int x, int y);
        logic hs, vs, de_e, ln, fr;
        hs   = !((x >= -144) && (x < -48));
        vs   = !((y >= -35) && (y < -33));
        de_e = (x >= 0) && (y >= 0);
        ln   = (x == -160);
        fr   = ln && (y == -45);
        return {16'(x), 16'(y), hs, vs, de_e, fr, ln};
    endfunction

    task automatic model_step();
        if (m_sx == 639) begin
            m_sx = -160;
            m_sy = (m_sy == 479) ? -45 : m_sy + 1;
        end else begin
            m_sx = m_sx + 1;
        end
    endtask

    task automatic test_reset();
        logic [36:0] exp_a, exp_v;
        logic [20:0] exp_t;
        exp_a = {16'(-160), 16'(-45), 5'b11000};
        exp_v = {16'(-256), 16'(-28), 5'b00000};
        exp_t = {8'(-8), 8'(-6), 5'b11000};
        rst_n = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_tests++;
            if (a_vec !== exp_a) begin
                n_fail++;
                $display("FAIL reset_480 cycle %0d: got %h expected %h", i, a_vec, exp_a);
            end
            n_tests++;
            if (v_vec !== exp_v) begin
                n_fail++;
                $display("FAIL reset_svga cycle %0d: got %h expected %h", i, v_vec, exp_v);
            end
        end
        n_tests++;
        if (t_vec !== exp_t) begin
            n_fail++;
            $display("FAIL reset_tiny: got %h expected %h", t_vec, exp_t);
        end
    endtask

    task automatic test_first_line();
        logic [36:0] got, want, bad_got, bad_want;
        int bad = 0, first_bad = -1, hs_fall = -1, hs_low = 0, line_at = -1;
        m_sx = -160;
        m_sy = -45;
        t_exp_q.push_back(32'd1200);
        t_exp_q.push_back(32'd2400);
        v_exp_q.push_back(32'd1056);
        v_exp_q.push_back(32'd2112);
        v_exp_q.push_back(32'd3168);
        rst_n = 1'b1;
        for (int n = 1; n <= 800; n++) begin
            @(posedge clk);
            model_step();
            exp_q.push_back(model_vec(m_sx, m_sy));
            @(negedge clk);
            got  = a_vec;
            want = exp_q.pop_front();
            if (got !== want) begin
                if (bad == 0) begin
                    first_bad = n; bad_got = got; bad_want = want;
                end
                bad++;
            end
            if (a_hsync === 1'b0) begin
                hs_low++;
                if (hs_fall < 0) hs_fall = n;
            end
            if (a_line === 1'b1 && line_at < 0) line_at = n;
        end
        n_tests++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL first_line_vectors: %0d bad cycles, first at %0d got %h expected %h",
                     bad, first_bad, bad_got, bad_want);
        end
        n_tests++;
        if (hs_fall !== 16) begin
            n_fail++;
            $display("FAIL hsync_start: got cycle %0d expected 16", hs_fall);
        end
        n_tests++;
        if (hs_low !== 96) begin
            n_fail++;
            $display("FAIL hsync_width: got %0d expected 96", hs_low);
        end
        n_tests++;
        if (line_at !== 800) begin
            n_fail++;
            $display("FAIL first_line_strobe: got cycle %0d expected 800", line_at);
        end
    endtask

    task automatic test_coherence();
        logic [36:0] got, want, bad_got, bad_want;
        int bad = 0, bad_coh = 0, first_bad = -1, steps = 0, last_line = 800, bad_period = 0;
        logic signed [15:0] prev_sx;
        prev_sx = a_sx;
        while (!(m_sx == 100 && m_sy == 0) && steps < 40000) begin
            @(posedge clk);
            model_step();
            exp_q.push_back(model_vec(m_sx, m_sy));
            @(negedge clk);
            steps++;
            got  = a_vec;
            want = exp_q.pop_front();
            if (got !== want) begin
                if (bad == 0) begin
                    first_bad = cyc; bad_got = got; bad_want = want;
                end
                bad++;
            end
            if (a_de !== ((a_sx >= 0) && (a_sy >= 0))) bad_coh++;
            if (a_frame === 1'b1 && !(a_sx == -160 && a_sy == -45)) bad_coh++;
            if (prev_sx == 639 && a_sx != -160) bad_coh++;
            if (a_line === 1'b1) begin
                if (cyc - last_line != 800) bad_period++;
                last_line = cyc;
            end
            prev_sx = a_sx;
        end
        n_tests++;
        if (!(m_sx == 100 && m_sy == 0)) begin
            n_fail++;
            $display("FAIL coherence_reach: stopped at model sx=%0d sy=%0d after %0d cycles", m_sx, m_sy, steps);
        end
        n_tests++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL coherence_vectors: %0d bad cycles, first at cycle %0d got %h expected %h",
                     bad, first_bad, bad_got, bad_want);
        end
        n_tests++;
        if (bad_coh !== 0) begin
            n_fail++;
            $display("FAIL coherence_flags: got %0d violations expected 0", bad_coh);
        end
        n_tests++;
        if (bad_period !== 0) begin
            n_fail++;
            $display("FAIL line_period: got %0d irregular strobes expected 0", bad_period);
        end
    endtask

    task automatic test_tiny_frames();
        logic [31:0] want, got;
        while (t_exp_q.size() > 0) begin
            want = t_exp_q.pop_front();
            got  = (t_obs_q.size() > 0) ? t_obs_q.pop_front() : 32'hFFFF_FFFF;
            n_tests++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL tiny_frame_stamp: got cycle %0d expected %0d", got, want);
            end
        end
        n_tests++;
        if (t_vs_cnt !== 80) begin
            n_fail++;
            $display("FAIL tiny_vsync_cycles: got %0d expected 80", t_vs_cnt);
        end
        n_tests++;
        if (t_de_cnt !== 768) begin
            n_fail++;
            $display("FAIL tiny_de_cycles: got %0d expected 768", t_de_cnt);
        end
    endtask

    task automatic test_svga();
        logic [31:0] want, got;
        while (v_exp_q.size() > 0) begin
            want = v_exp_q.pop_front();
            got  = (v_obs_q.size() > 0) ? v_obs_q.pop_front() : 32'hFFFF_FFFF;
            n_tests++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL svga_line_stamp: got cycle %0d expected %0d", got, want);
            end
        end
        n_tests++;
        if (v_hs_cnt !== 128) begin
            n_fail++;
            $display("FAIL svga_hsync_high: got %0d expected 128", v_hs_cnt);
        end
        n_tests++;
        if (v_vs_rise !== 1056) begin
            n_fail++;
            $display("FAIL svga_vsync_rise: got cycle %0d expected 1056", v_vs_rise);
        end
    endtask

    task automatic test_mid_reset();
        logic [36:0] exp_a, got, want;
        int bad_hold = 0, bad = 0, early = 0, line_at = -1;
        exp_a = {16'(-160), 16'(-45), 5'b11000};
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if (a_vec !== exp_a) begin
            n_fail++;
            $display("FAIL mid_reset_async: got %h expected %h", a_vec, exp_a);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (a_vec !== exp_a) bad_hold++;
        end
        n_tests++;
        if (bad_hold !== 0) begin
            n_fail++;
            $display("FAIL mid_reset_hold: got %0d bad cycles expected 0", bad_hold);
        end
        m_sx = -160;
        m_sy = -45;
        rst_n = 1'b1;
        for (int n = 1; n <= 800; n++) begin
            @(posedge clk);
            model_step();
            exp_q.push_back(model_vec(m_sx, m_sy));
            @(negedge clk);
            got  = a_vec;
            want = exp_q.pop_front();
            if (got !== want) bad++;
            if (a_line === 1'b1 && line_at < 0) line_at = n;
            if (n < 800 && (a_line !== 1'b0 || a_frame !== 1'b0)) early++;
        end
        n_tests++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL mid_reset_vectors: got %0d bad cycles expected 0", bad);
        end
        n_tests++;
        if (early !== 0) begin
            n_fail++;
            $display("FAIL mid_reset_glitch: got %0d early strobes expected 0", early);
        end
        n_tests++;
        if (line_at !== 800) begin
            n_fail++;
            $display("FAIL mid_reset_line: got cycle %0d expected 800", line_at);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_first_line();
        test_coherence();
        test_tiny_frames();
        test_svga();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
